// File: rtl/display_scan_controller.sv
// Scan sequencer for a 4-digit multiplexed 7-segment display: blanking gaps
// between digits, a once-per-frame digit snapshot, and blinking of the adjusted field.
module display_scan_controller #(
  parameter int ON_CYCLES    = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int BLINK_DIV    = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       adj,
  input  logic       sel,
  input  logic [3:0] s0,
  input  logic [3:0] s1,
  input  logic [3:0] m0,
  input  logic [3:0] m1,
  output logic [3:0] an,
  output logic [7:0] segment,
  output logic       frame_start
);

  localparam int CNT_MAX = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int BW      = $clog2(BLINK_DIV + 1);

  typedef enum logic {S_BLANK, S_ON} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [BW-1:0] blinkCnt_q, blinkCnt_d;
  logic          blinkPhase_q, blinkPhase_d;
  logic [3:0]    snap_q [4];
  logic [3:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;
  logic          frameStart_q;
  logic          snapLoad;
  logic          fieldBlanked;

  function automatic logic [7:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 8'hC0;
      4'd1:    decode = 8'hF9;
      4'd2:    decode = 8'hA4;
      4'd3:    decode = 8'hB0;
      4'd4:    decode = 8'h99;
      4'd5:    decode = 8'h92;
      4'd6:    decode = 8'h82;
      4'd7:    decode = 8'hF8;
      4'd8:    decode = 8'h80;
      4'd9:    decode = 8'h90;
      default: decode = 8'hFF;
    endcase
  endfunction

  // Outputs are computed from the next scan position so they line up with the state register.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    idx_d        = idx_q;
    blinkCnt_d   = '0;
    blinkPhase_d = 1'b0;
    an_d         = 4'hF;
    seg_d        = 8'hFF;
    snapLoad     = (state_q == S_BLANK) && (idx_q == 2'd0) && (cnt_q == '0);

    case (state_q)
      S_BLANK: begin
        if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
          state_d = S_ON;
          cnt_d   = '0;
        end
      end
      S_ON: begin
        if (cnt_q == CW'(ON_CYCLES - 1)) begin
          state_d = S_BLANK;
          cnt_d   = '0;
          idx_d   = idx_q + 2'd1;
        end
      end
      default: begin
        state_d = S_BLANK;
        cnt_d   = '0;
      end
    endcase

    if (adj) begin
      blinkPhase_d = blinkPhase_q;
      if (blinkCnt_q == BW'(BLINK_DIV - 1)) begin
        blinkPhase_d = ~blinkPhase_q;
      end else begin
        blinkCnt_d = blinkCnt_q + 1'b1;
      end
    end

    // sel=1 owns the seconds digits (idx 0,1), sel=0 the minutes digits (idx 2,3).
    fieldBlanked = adj && blinkPhase_q && (sel ? ~idx_d[1] : idx_d[1]);
    if (state_d == S_ON) begin
      an_d  = ~(4'b0001 << idx_d);
      seg_d = fieldBlanked ? 8'hFF : decode(snap_q[idx_d]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_BLANK;
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      blinkCnt_q   <= '0;
      blinkPhase_q <= 1'b0;
      an_q         <= 4'hF;
      seg_q        <= 8'hFF;
      frameStart_q <= 1'b0;
      for (int i = 0; i < 4; i++) snap_q[i] <= 4'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      blinkCnt_q   <= blinkCnt_d;
      blinkPhase_q <= blinkPhase_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frameStart_q <= snapLoad;
      if (snapLoad) begin
        snap_q[0] <= s0;
        snap_q[1] <= s1;
        snap_q[2] <= m0;
        snap_q[3] <= m1;
      end
    end
  end

  assign an          = an_q;
  assign segment     = seg_q;
  assign frame_start = frameStart_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller: directed and random stimulus checked every
// cycle against a frame-arithmetic model of the scan, snapshot and blink rules.
module tb_display_scan_controller;

  localparam int ON   = 4;
  localparam int BL   = 2;
  localparam int BD   = 8;
  localparam int DIG  = ON + BL;
  localparam int FRM  = 4 * DIG;
  localparam int MAXC = 1024;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       adj = 1'b0;
  logic       sel = 1'b0;
  logic [3:0] s0 = 4'd0, s1 = 4'd0, m0 = 4'd0, m1 = 4'd0;
  logic [3:0] an;
  logic [7:0] segment;
  logic       frame_start;

  int nAssert = 0;
  int nFail   = 0;
  int t       = 0;

  logic [3:0] dH [MAXC][4];
  logic       adjH [MAXC];
  logic       selH [MAXC];
  int         kArr [MAXC+1];
  logic [7:0] decTab [16];

  display_scan_controller #(
    .ON_CYCLES(ON), .BLANK_CYCLES(BL), .BLINK_DIV(BD)
  ) dut (
    .clk(clk), .rst(rst), .adj(adj), .sel(sel),
    .s0(s0), .s1(s1), .m0(m0), .m1(m1),
    .an(an), .segment(segment), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Expected outputs come from the cycle index since reset release: the frame snapshot
  // is the input seen in the frame's first cycle, and kArr counts consecutive adj-high cycles.
  task automatic checkOutput();
    int p, d, q;
    logic [3:0] eAn;
    logic [7:0] eSeg;
    logic       eFs;
    p    = t % FRM;
    d    = p / DIG;
    q    = p % DIG;
    eFs  = (p == 1);
    eAn  = 4'hF;
    eSeg = 8'hFF;
    if (q >= BL) begin
      eAn  = 4'hF & ~(4'b0001 << d);
      eSeg = decTab[dH[t-p][d]];
      if (adjH[t-1] && (((kArr[t-1] / BD) % 2) == 1) && (selH[t-1] ? (d < 2) : (d >= 2)))
        eSeg = 8'hFF;
    end
    nAssert++;
    assert (an === eAn) else begin
      nFail++;
      $error("[TB] FAIL an t=%0d observed=%b expected=%b", t, an, eAn);
    end
    nAssert++;
    assert (segment === eSeg) else begin
      nFail++;
      $error("[TB] FAIL segment t=%0d observed=%h expected=%h", t, segment, eSeg);
    end
    nAssert++;
    assert (frame_start === eFs) else begin
      nFail++;
      $error("[TB] FAIL frame_start t=%0d observed=%b expected=%b", t, frame_start, eFs);
    end
  endtask

  // Called just after a rising edge; drives one cycle's inputs and checks at the falling edge.
  task automatic applyStimulus(input logic a, input logic sl,
                               input logic [3:0] v0, input logic [3:0] v1,
                               input logic [3:0] v2, input logic [3:0] v3);
    if (t < MAXC - 1) begin
      adj = a; sel = sl; s0 = v0; s1 = v1; m0 = v2; m1 = v3;
      adjH[t] = a;
      selH[t] = sl;
      dH[t][0] = v0; dH[t][1] = v1; dH[t][2] = v2; dH[t][3] = v3;
      kArr[t+1] = a ? kArr[t] + 1 : 0;
      @(negedge clk);
      checkOutput();
      @(posedge clk);
      #1;
      t++;
    end
  endtask

  function automatic logic [3:0] rndDigit();
    return (($urandom % 6) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
  endfunction

  // Reset is raised mid-cycle and must clear the outputs without waiting for an edge.
  task automatic doReset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    nAssert++;
    assert (an === 4'hF) else begin
      nFail++; $error("[TB] FAIL reset_an observed=%b expected=%b", an, 4'hF);
    end
    nAssert++;
    assert (segment === 8'hFF) else begin
      nFail++; $error("[TB] FAIL reset_seg observed=%h expected=%h", segment, 8'hFF);
    end
    nAssert++;
    assert (frame_start === 1'b0) else begin
      nFail++; $error("[TB] FAIL reset_fs observed=%b expected=%b", frame_start, 1'b0);
    end
    @(posedge clk);
    #1;
    rst     = 1'b0;
    t       = 0;
    kArr[0] = 0;
  endtask

  initial begin
    decTab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
               8'h80, 8'h90, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

    doReset();
    $display("[TB] plain scan");
    for (int i = 0; i < 2 * FRM; i++) applyStimulus(1'b0, 1'b0, 4'd1, 4'd2, 4'd3, 4'd4);

    $display("[TB] tearing and invalid BCD");
    for (int i = 0; i < FRM; i++)
      applyStimulus(1'b0, 1'b0, (i >= 2 * DIG) ? 4'd7 : 4'd1, 4'd2, 4'd3, 4'd4);
    for (int i = 0; i < 2 * FRM; i++) applyStimulus(1'b0, 1'b0, 4'd7, 4'd2, 4'd3, 4'hC);

    $display("[TB] blink");
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1'b1, 4'd5, 4'd9, 4'd0, 4'd8);
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1'b0, 4'd5, 4'd9, 4'd0, 4'd8);
    for (int i = 0; i < 30; i++) applyStimulus(1'b0, 1'b0, 4'd5, 4'd9, 4'd0, 4'd8);

    $display("[TB] random");
    begin
      logic a, sl;
      a = 1'b0; sl = 1'b0;
      for (int i = 0; i < 300; i++) begin
        if (($urandom % 25) == 0) a = ~a;
        if (($urandom % 15) == 0) sl = ~sl;
        applyStimulus(a, sl, rndDigit(), rndDigit(), rndDigit(), rndDigit());
      end
      while (((t % FRM) % DIG) < BL + 1)
        applyStimulus(a, sl, rndDigit(), rndDigit(), rndDigit(), rndDigit());
    end

    $display("[TB] reset while lit");
    doReset();
    begin
      logic a, sl;
      a = 1'b1; sl = 1'b1;
      for (int i = 0; i < 150; i++) begin
        if (($urandom % 20) == 0) a = ~a;
        if (($urandom % 12) == 0) sl = ~sl;
        applyStimulus(a, sl, rndDigit(), rndDigit(), rndDigit(), rndDigit());
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
